// File: rtl/md5_pkg.sv
// md5_pkg: shared chunk layout constants and generator state type
package md5_pkg;
    localparam int CHUNK_W       = 512;
    localparam int LEN_LSB       = 448;
    localparam logic [7:0] PAD_BYTE = 8'h80;
    localparam int MAX_MSG_BYTES = 55;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} gen_state_t;
endpackage

// File: rtl/md5_pad_encoder.sv
// md5_pad_encoder: turns a counter value into a padded single-block MD5 chunk
module md5_pad_encoder
    import md5_pkg::*;
#(
    parameter int MAX_BYTES = 32
) (
    input  logic [8*MAX_BYTES-1:0] v,
    output logic [CHUNK_W-1:0]     chunk
);
    localparam int VW = 8 * MAX_MSG_BYTES;
    logic [VW-1:0] vp;
    int            len;
    assign vp = VW'(v);
    // message length is the highest non-zero byte index + 1 (zero still occupies one byte)
    always_comb begin
        len = 1;
        for (int i = 1; i < MAX_BYTES; i++) if (vp[8*i +: 8] != 8'h00) len = i + 1;
        chunk = '0;
        for (int i = 0; i < MAX_MSG_BYTES; i++)
            chunk[8*i +: 8] = (i < len) ? vp[8*i +: 8] : (i == len ? PAD_BYTE : 8'h00);
        chunk[CHUNK_W-1:LEN_LSB] = 64'(len * 8);
    end
endmodule

// File: rtl/md5_candidate_chunk_gen.sv
// md5_candidate_chunk_gen: streams padded candidate chunks over a counter range; MD5_CHUNK_GEN_STATS_EN adds chunks_sent
module md5_candidate_chunk_gen
    import md5_pkg::*;
#(
    parameter int MAX_BYTES = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [8*MAX_BYTES-1:0] start_value,
    input  logic [8*MAX_BYTES-1:0] end_value,
    input  logic [7:0]             stride,
    output logic [CHUNK_W-1:0]     chunk,
    output logic                   chunk_valid,
    input  logic                   chunk_ready,
    output logic                   chunk_last,
    output logic                   busy,
`ifdef MD5_CHUNK_GEN_STATS_EN
    output logic [63:0]            chunks_sent,
`endif
    output logic                   done
);
    localparam int CW = 8 * MAX_BYTES;
    gen_state_t         state_q;
    logic [CW-1:0]      counter_q, end_q;
    logic [7:0]         stride_q;
    logic [CW:0]        counter_d;
    logic [CHUNK_W-1:0] chunk_q, load_chunk, next_chunk;
    logic               valid_q, done_q, accept;

    md5_pad_encoder #(.MAX_BYTES(MAX_BYTES)) u_load_enc (.v(start_value), .chunk(load_chunk));
    md5_pad_encoder #(.MAX_BYTES(MAX_BYTES)) u_next_enc (.v(counter_d[CW-1:0]), .chunk(next_chunk));

    // one extra bit catches wrap-around so the range ends instead of restarting at zero
    assign counter_d   = {1'b0, counter_q} + (CW+1)'(stride_q);
    assign accept      = valid_q && chunk_ready;
    assign chunk_last  = valid_q && (counter_d[CW] || counter_d[CW-1:0] > end_q);
    assign chunk       = chunk_q;
    assign chunk_valid = valid_q;
    assign busy        = state_q != IDLE;
    assign done        = done_q;

    // FSM: load on start, advance with preloaded next chunk on accept, pulse done after the final accept
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            end_q     <= '0;
            stride_q  <= 8'd1;
            chunk_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        state_q   <= RUN;
                        counter_q <= start_value;
                        end_q     <= end_value;
                        stride_q  <= (stride == 8'd0) ? 8'd1 : stride;
                        chunk_q   <= load_chunk;
                        valid_q   <= 1'b1;
                    end
                    RUN: if (accept) begin
                        if (chunk_last) begin
                            state_q <= DRAIN;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            counter_q <= counter_d[CW-1:0];
                            chunk_q   <= next_chunk;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef MD5_CHUNK_GEN_STATS_EN
    logic [63:0] sent_q;
    assign chunks_sent = sent_q;
    // saturating accept counter; an accept coinciding with abort still counts
    always_ff @(posedge clk) begin
        if (reset || (state_q == IDLE && start && !abort)) sent_q <= '0;
        else if (accept && sent_q != '1) sent_q <= sent_q + 64'd1;
    end
`endif
endmodule

// File: tb/tb_md5_candidate_chunk_gen.sv
// tb_md5_candidate_chunk_gen: scoreboard bench for the candidate chunk generator
module tb_md5_candidate_chunk_gen;
    typedef struct {logic [511:0] c; logic l;} exp_t;

    logic         clk = 0, reset = 1, start = 0, abort = 0, chunk_ready = 0;
    logic [255:0] start_value = '0, end_value = '0;
    logic [7:0]   stride = 8'd1;
    logic [511:0] chunk;
    logic         chunk_valid, chunk_last, busy, done;

    logic         start2 = 0, abort2 = 0, ready2 = 1;
    logic [15:0]  sv2 = '0, ev2 = '0;
    logic [511:0] chunk2;
    logic         valid2, last2, busy2, done2;

    int errors = 0, checks = 0;
    exp_t q[$];
    logic mon_en = 0, exp_done = 0, prev_hold = 0, prev_last = 0;
    logic [511:0] prev_chunk = '0;
    longint unsigned sent_exp = 0;

`ifdef MD5_CHUNK_GEN_STATS_EN
    logic [63:0] chunks_sent, chunks_sent2;
`endif

    md5_candidate_chunk_gen #(.MAX_BYTES(32)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .start_value(start_value), .end_value(end_value), .stride(stride),
        .chunk(chunk), .chunk_valid(chunk_valid), .chunk_ready(chunk_ready),
        .chunk_last(chunk_last), .busy(busy),
`ifdef MD5_CHUNK_GEN_STATS_EN
        .chunks_sent(chunks_sent),
`endif
        .done(done));

    md5_candidate_chunk_gen #(.MAX_BYTES(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2),
        .start_value(sv2), .end_value(ev2), .stride(8'd1),
        .chunk(chunk2), .chunk_valid(valid2), .chunk_ready(ready2),
        .chunk_last(last2), .busy(busy2),
`ifdef MD5_CHUNK_GEN_STATS_EN
        .chunks_sent(chunks_sent2),
`endif
        .done(done2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] enc(input logic [255:0] v);
        logic [255:0] t;
        logic [511:0] r;
        int len;
        r = '0;
        len = 1;
        t = v >> 8;
        while (t != 0) begin
            len++;
            t = t >> 8;
        end
        for (int i = 0; i < len; i++) r[8*i +: 8] = v[8*i +: 8];
        r[8*len +: 8] = 8'h80;
        r[511:448] = 64'(len * 8);
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("done", done, exp_done);
            if (prev_hold) begin
                chk("hold_chunk", chunk, prev_chunk);
                chk("hold_last", chunk_last, prev_last);
            end
        end
        exp_done = 0;
        if (mon_en && chunk_valid && chunk_ready && !reset) begin
            chk("pop_avail", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("chunk", chunk, e.c);
                chk("last", chunk_last, e.l);
                exp_done = e.l && !abort;
            end
            sent_exp++;
        end
        prev_hold  = chunk_valid && !chunk_ready && !abort && !reset;
        prev_chunk = chunk;
        prev_last  = chunk_last;
    end

    task automatic run(input logic [255:0] s, input logic [255:0] e, input logic [7:0] st, input int bp);
        logic [256:0] v, n;
        exp_t x;
        bit got;
        v = {1'b0, s};
        forever begin
            n = v + ((st == 0) ? 257'd1 : 257'(st));
            x.c = enc(v[255:0]);
            x.l = n[256] || n[255:0] > e;
            q.push_back(x);
            if (x.l) break;
            v = n;
        end
        @(posedge clk) #1;
        start = 1; start_value = s; end_value = e; stride = st; sent_exp = 0;
        @(posedge clk) #1;
        start = 0;
        got = 0;
        for (int c = 0; c < 400 && !got; c++) begin
            chunk_ready = !(bp >= 0 && c >= bp && c < bp + 3);
            @(negedge clk);
            if (done) got = 1;
            @(posedge clk) #1;
        end
        chk("done_seen", got, 1);
        chk("queue_empty", q.size(), 0);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", chunk_valid, 0);
`ifdef MD5_CHUNK_GEN_STATS_EN
        chk("chunks_sent", chunks_sent, sent_exp);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_chunk", chunk, 0);
        chk("rst_valid", chunk_valid, 0);
        chk("rst_last", chunk_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        mon_en = 1;
        run(256'd0, 256'd2, 8'd1, -1);
        run(256'hFF, 256'h100, 8'd1, -1);
        run(256'h1000, 256'h1010, 8'd1, 4);
        run(256'd1, 256'd10, 8'd4, 1);
        run(256'd3, 256'd6, 8'd0, -1);
        run(256'd5, 256'd3, 8'd1, -1);
        run({256{1'b1}} - 256'd1, {256{1'b1}}, 8'd3, -1);
        for (int k = 0; k < 100; k++) begin
            exp_t x;
            x.c = enc(256'(k));
            x.l = 0;
            q.push_back(x);
        end
        @(posedge clk) #1;
        start = 1; start_value = 256'd0; end_value = 256'd100; stride = 8'd1; chunk_ready = 1; sent_exp = 0;
        @(posedge clk) #1;
        start = 0;
        repeat (4) @(posedge clk);
        #1 abort = 1;
        @(posedge clk) #1;
        abort = 0;
        q.delete();
        @(negedge clk);
        chk("abort_valid", chunk_valid, 0);
        chk("abort_busy", busy, 0);
`ifdef MD5_CHUNK_GEN_STATS_EN
        chk("abort_sent", chunks_sent, sent_exp);
`endif
        run(256'h1234, 256'h1236, 8'd1, -1);
        for (int k = 0; k < 50; k++) begin
            exp_t x;
            x.c = enc(256'(k + 7));
            x.l = 0;
            q.push_back(x);
        end
        @(posedge clk) #1;
        start = 1; start_value = 256'd7; end_value = 256'd60; chunk_ready = 1;
        @(posedge clk) #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1; chunk_ready = 0;
        @(posedge clk) #1;
        reset = 0;
        q.delete();
        sent_exp = 0;
        @(negedge clk);
        chk("rrst_valid", chunk_valid, 0);
        chk("rrst_busy", busy, 0);
        chk("rrst_chunk", chunk, 0);
        run(256'hABCDEF, 256'hABCDF1, 8'd2, 0);
        @(posedge clk) #1;
        start2 = 1; sv2 = 16'hFFFF; ev2 = 16'hFFFF;
        @(posedge clk) #1;
        start2 = 0;
        @(negedge clk);
        chk("c2_valid", valid2, 1);
        chk("c2_last", last2, 1);
        chk("c2_chunk", chunk2, enc(256'h0000FFFF));
        @(negedge clk);
        chk("c2_done", done2, 1);
        chk("c2_valid_off", valid2, 0);
        @(negedge clk);
        chk("c2_busy", busy2, 0);
        chk("c2_done_off", done2, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
